// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared size/state encodings and helpers for data_memory_hs.
//           Build option: DMEM_MISALIGN_TRAP_EN (misaligned access trapping).
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Little-endian lane mask / store replication and load extraction
//           with sign or zero extension.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic        i_unsigned,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_shift;

  assign w_shift = 16'(i_rword >> {i_offset, 3'b000});

  always_comb begin
    o_mask  = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      SIZE_BYTE: begin
        o_mask  = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
      end
      SIZE_HALF: begin
        o_mask  = 4'b0011 << i_offset;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      end
      SIZE_WORD: begin
        o_mask  = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_hs
// Brief   : Handshaked byte/half/word data RAM with programmable wait states.
//           Build option: DMEM_MISALIGN_TRAP_EN rejects misaligned accesses.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Ready,
  output logic        Error
);

  localparam int         c_aw        = $clog2(DEPTH);
  localparam logic [7:0] c_wait_init = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cnt;
  logic [c_aw+1:0] r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_write;
  logic            r_bad;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH] = '{default: '0};

  logic            w_idle;
  logic            w_req;
  logic            w_enter_done;
  logic            w_cur_write;
  logic            w_cur_uns;
  logic            w_bad;
  logic            w_err;
  logic            w_mem_we;
  logic [c_aw+1:0] w_cur_addr;
  logic [31:0]     w_cur_wdata;
  logic [31:0]     w_rword;
  logic [31:0]     w_wrep;
  logic [31:0]     w_load;
  logic [1:0]      w_cur_size;
  logic [1:0]      w_off;
  logic [3:0]      w_mask;
  logic [c_aw-1:0] w_idx;
  logic            w_unused;

  assign w_unused = &{1'b0, Address[31:c_aw+2]};

  // With zero wait states the access happens on the accepting edge, so the
  // live request inputs are used in IDLE and the captured copy afterwards.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_req       = MemRead | MemWrite;
  assign w_cur_addr  = w_idle ? Address[c_aw+1:0] : r_addr;
  assign w_cur_wdata = w_idle ? WriteData : r_wdata;
  assign w_cur_size  = w_idle ? Size : r_size;
  assign w_cur_uns   = w_idle ? Unsigned : r_uns;
  assign w_cur_write = w_idle ? MemWrite : r_write;
  assign w_bad       = w_idle ? ((MemRead & MemWrite) | (Size == 2'b11)) : r_bad;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_off = w_cur_addr[1:0];
  assign w_err = w_bad | is_misaligned(w_cur_size, w_cur_addr[1:0]);
`else
  always_comb begin
    w_off = w_cur_addr[1:0];
    if (w_cur_size == SIZE_HALF) begin
      w_off[0] = 1'b0;
    end else if (w_cur_size == SIZE_WORD) begin
      w_off = 2'b00;
    end
  end
  assign w_err = w_bad;
`endif

  assign w_idx        = w_cur_addr[c_aw+1:2];
  assign w_rword      = r_mem[w_idx];
  assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
  assign w_mem_we     = w_enter_done & w_cur_write & ~w_err & ~Rst;

  dmem_lane_align u_align (
    .i_size     (w_cur_size),
    .i_offset   (w_off),
    .i_wdata    (w_cur_wdata),
    .i_rword    (w_rword),
    .i_unsigned (w_cur_uns),
    .o_mask     (w_mask),
    .o_wdata    (w_wrep),
    .o_rdata    (w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (r_cnt == 8'd0) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_write <= 1'b0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_req) begin
        r_cnt   <= c_wait_init;
        r_addr  <= Address[c_aw+1:0];
        r_wdata <= WriteData;
        r_size  <= Size;
        r_uns   <= Unsigned;
        r_write <= MemWrite;
        r_bad   <= (MemRead & MemWrite) | (Size == 2'b11);
      end else if ((r_state == ST_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_enter_done) begin
        r_err <= w_err;
        if (!w_cur_write && !w_err) r_rdata <= w_load;
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
  end

  assign ReadData = r_rdata;
  assign Busy     = (r_state == ST_WAIT);
  assign Ready    = (r_state == ST_DONE);
  assign Error    = (r_state == ST_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_hs
// Brief   : Self-checking bench: zero- and three-wait-state instances share
//           stimulus and are compared against a byte-level memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_memory_hs;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0, WriteData = '0;
  logic [1:0]  Size = '0;
  logic        Unsigned = 1'b0;
  logic        MemWrite0 = 1'b0, MemRead0 = 1'b0, MemWrite3 = 1'b0, MemRead3 = 1'b0;
  logic [31:0] rd0, rd3;
  logic        busy0, rdy0, err0, busy3, rdy3, err3;

  int n_chk = 0;
  int n_fail = 0;

  int o_rdy0_cnt, o_rdy0_at, o_rdy3_cnt, o_rdy3_at, o_busy0, o_busy3;
  logic o_err0, o_err3;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd;
  logic        m_err;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  data_memory_hs #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(clk), .Rst(rst), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite0), .MemRead(MemRead0), .Size(Size), .Unsigned(Unsigned),
    .ReadData(rd0), .Busy(busy0), .Ready(rdy0), .Error(err0));

  data_memory_hs #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .Clk(clk), .Rst(rst), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite3), .MemRead(MemRead3), .Size(Size), .Unsigned(Unsigned),
    .ReadData(rd3), .Busy(busy3), .Ready(rdy3), .Error(err3));

  // Byte-granular reference: address arithmetic on plain integers.
  task automatic model_req(input bit we, input bit re, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input bit un);
    int unsigned ba, n, w, lane;
    logic [31:0] val;
    m_err = (we && re) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) m_err = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) m_err = 1'b1;
    ba = a;
`else
    ba = (sz == 2'd1) ? (a & ~32'd1) : (sz == 2'd2) ? (a & ~32'd3) : a;
`endif
    if (m_err) return;
    n = 1 << sz;
    w = (ba / 4) % DEPTH;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        lane = (ba % 4) + i;
        m_mem[w][8*lane +: 8] = wd[8*i +: 8];
      end
    end else begin
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
        lane = (ba % 4) + i;
        val[8*i +: 8] = m_mem[w][8*lane +: 8];
      end
      if (!un && n < 4 && val[8*n-1]) begin
        for (int j = n; j < 4; j++) val[8*j +: 8] = 8'hFF;
      end
      m_rd = val;
    end
  endtask

  // Presents one request for a single edge, then observes both instances
  // for six cycles and updates the model.
  task automatic drive_req(input bit we, input bit re, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input bit un);
    @(negedge clk);
    Address = a; WriteData = wd; Size = sz; Unsigned = un;
    MemWrite0 = we; MemRead0 = re; MemWrite3 = we; MemRead3 = re;
    @(posedge clk); #1;
    MemWrite0 = 0; MemRead0 = 0; MemWrite3 = 0; MemRead3 = 0;
    Address = $urandom(); WriteData = $urandom(); Size = 2'($urandom()); Unsigned = 1'($urandom());
    o_rdy0_cnt = 0; o_rdy0_at = -1; o_rdy3_cnt = 0; o_rdy3_at = -1;
    o_busy0 = 0; o_busy3 = 0; o_err0 = 1'b0; o_err3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rdy0) begin o_rdy0_cnt++; o_rdy0_at = c; o_err0 = err0; end
      if (rdy3) begin o_rdy3_cnt++; o_rdy3_at = c; o_err3 = err3; end
      if (busy0) o_busy0++;
      if (busy3) o_busy3++;
      @(posedge clk); #1;
    end
    model_req(we, re, a, wd, sz, un);
  endtask

  task automatic test_reset();
    n_chk++;
    if ({rd0, busy0, rdy0, err0} !== 35'h0) begin
      n_fail++; $display("FAIL reset_dut0: got rd=%h busy=%b ready=%b err=%b, want all 0", rd0, busy0, rdy0, err0);
    end
    n_chk++;
    if ({rd3, busy3, rdy3, err3} !== 35'h0) begin
      n_fail++; $display("FAIL reset_dut3: got rd=%h busy=%b ready=%b err=%b, want all 0", rd3, busy3, rdy3, err3);
    end
  endtask

  task automatic test_word();
    drive_req(1, 0, 32'h0, 32'h12345678, 2'd2, 0);
    n_chk++;
    if (o_rdy0_at !== 0 || o_rdy0_cnt !== 1 || o_err0 !== 1'b0) begin
      n_fail++; $display("FAIL word_store_ready0: at=%0d cnt=%0d err=%b, want at=0 cnt=1 err=0", o_rdy0_at, o_rdy0_cnt, o_err0);
    end
    drive_req(0, 1, 32'h0, 32'h0, 2'd2, 0);
    n_chk++;
    if (rd0 !== 32'h12345678 || rd3 !== 32'h12345678) begin
      n_fail++; $display("FAIL word_load: got %h/%h, want 12345678", rd0, rd3);
    end
  endtask

  task automatic test_byte_signed();
    drive_req(1, 0, 32'h5, 32'h5A5A5AAB, 2'd0, 0);
    n_chk++;
    if (o_busy3 !== 3 || o_rdy3_at !== 3 || o_rdy3_cnt !== 1) begin
      n_fail++; $display("FAIL byte_store_timing3: busy=%0d ready_at=%0d cnt=%0d, want 3/3/1", o_busy3, o_rdy3_at, o_rdy3_cnt);
    end
    drive_req(0, 1, 32'h5, 32'h0, 2'd0, 0);
    n_chk++;
    if (rd0 !== 32'hFFFFFFAB || rd3 !== 32'hFFFFFFAB) begin
      n_fail++; $display("FAIL byte_load_signed: got %h/%h, want ffffffab", rd0, rd3);
    end
    drive_req(0, 1, 32'h5, 32'h0, 2'd0, 1);
    n_chk++;
    if (rd0 !== 32'h000000AB || rd3 !== 32'h000000AB) begin
      n_fail++; $display("FAIL byte_load_unsigned: got %h/%h, want 000000ab", rd0, rd3);
    end
  endtask

  task automatic test_half_wrap();
    drive_req(1, 0, 32'h8, 32'hFFFFFFFF, 2'd2, 0);
    drive_req(1, 0, 32'h8, 32'h1234EF98, 2'd1, 0);
    drive_req(0, 1, 32'h8, 32'h0, 2'd2, 0);
    n_chk++;
    if (rd0 !== 32'hFFFFEF98 || rd3 !== 32'hFFFFEF98) begin
      n_fail++; $display("FAIL half_store: got %h/%h, want ffffef98", rd0, rd3);
    end
    drive_req(0, 1, 32'h0, 32'h0, 2'd2, 0);
    drive_req(0, 1, 32'h8 + 4 * DEPTH, 32'h0, 2'd2, 0);
    n_chk++;
    if (rd0 !== 32'hFFFFEF98 || rd3 !== 32'hFFFFEF98) begin
      n_fail++; $display("FAIL addr_wrap: got %h/%h, want ffffef98", rd0, rd3);
    end
  endtask

  task automatic test_reject();
    drive_req(1, 1, 32'h8, 32'h0, 2'd2, 0);
    n_chk++;
    if (o_err0 !== 1'b1 || o_err3 !== 1'b1 || o_rdy0_cnt !== 1 || o_rdy3_at !== 3) begin
      n_fail++; $display("FAIL reject_both: err=%b/%b ready0_cnt=%0d ready3_at=%0d, want 1/1 1 3", o_err0, o_err3, o_rdy0_cnt, o_rdy3_at);
    end
    drive_req(1, 0, 32'h8, 32'h0, 2'd3, 0);
    n_chk++;
    if (o_err0 !== 1'b1 || o_err3 !== 1'b1) begin
      n_fail++; $display("FAIL reject_size_store: err=%b/%b, want 1/1", o_err0, o_err3);
    end
    drive_req(0, 1, 32'h0, 32'h0, 2'd3, 0);
    n_chk++;
    if (o_err0 !== 1'b1 || rd0 !== 32'hFFFFEF98 || rd3 !== 32'hFFFFEF98) begin
      n_fail++; $display("FAIL reject_size_load: err=%b rd=%h/%h, want 1 ffffef98", o_err0, rd0, rd3);
    end
    drive_req(0, 1, 32'h0, 32'h0, 2'd2, 0);
    drive_req(0, 1, 32'h8, 32'h0, 2'd2, 0);
    n_chk++;
    if (rd0 !== 32'hFFFFEF98 || rd3 !== 32'hFFFFEF98 || o_err3 !== 1'b0) begin
      n_fail++; $display("FAIL reject_mem_kept: got %h/%h err=%b, want ffffef98 err 0", rd0, rd3, o_err3);
    end
  endtask

  task automatic test_misalign();
    drive_req(1, 0, 32'h0, 32'hCAFEF00D, 2'd2, 0);
    drive_req(0, 1, 32'h8, 32'h0, 2'd2, 0);
    drive_req(0, 1, 32'h2, 32'h0, 2'd2, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_chk++;
    if (o_err0 !== 1'b1 || o_err3 !== 1'b1 || rd0 !== 32'hFFFFEF98 || rd3 !== 32'hFFFFEF98) begin
      n_fail++; $display("FAIL misalign_trap: err=%b/%b rd=%h/%h, want 1/1 ffffef98", o_err0, o_err3, rd0, rd3);
    end
`else
    n_chk++;
    if (o_err0 !== 1'b0 || o_err3 !== 1'b0 || rd0 !== 32'hCAFEF00D || rd3 !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL misalign_force: err=%b/%b rd=%h/%h, want 0/0 cafef00d", o_err0, o_err3, rd0, rd3);
    end
`endif
  endtask

  task automatic test_reset_midop();
    int rdy_seen;
    @(negedge clk);
    Address = 32'h4; WriteData = 32'h11111111; Size = 2'd2; Unsigned = 1'b0; MemWrite3 = 1'b1;
    @(posedge clk); #1;
    MemWrite3 = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy3 !== 1'b1) begin
      n_fail++; $display("FAIL midop_busy: got busy=%b, want 1", busy3);
    end
    rst = 1'b1;
    #1;
    m_rd = 32'h0;
    n_chk++;
    if ({rd0, busy0, rdy0, err0, rd3, busy3, rdy3, err3} !== 70'h0) begin
      n_fail++; $display("FAIL midop_reset_outputs: rd=%h/%h busy=%b/%b ready=%b/%b, want all 0", rd0, rd3, busy0, busy3, rdy0, rdy3);
    end
    @(negedge clk); rst = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rdy3 || rdy0) rdy_seen++;
    end
    n_chk++;
    if (rdy_seen !== 0) begin
      n_fail++; $display("FAIL midop_no_ready: saw %0d ready cycles, want 0", rdy_seen);
    end
    drive_req(0, 1, 32'h4, 32'h0, 2'd2, 0);
    n_chk++;
    if (rd0 !== 32'h0000AB00 || rd3 !== 32'h0000AB00 || rd3 !== m_rd) begin
      n_fail++; $display("FAIL midop_store_discarded: got %h/%h, want 0000ab00", rd0, rd3);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic [1:0]  sz;
    bit          we, re, un;
    int          r;
    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 19);
      we = (r < 10);
      re = (r >= 10) || (r == 0);
      a  = $urandom_range(0, 63) + ($urandom_range(0, 3) << 6);
      wd = $urandom();
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      un = 1'($urandom());
      drive_req(we, re, a, wd, sz, un);
      n_chk++;
      if (o_rdy0_cnt !== 1 || o_rdy0_at !== 0 || o_rdy3_cnt !== 1 || o_rdy3_at !== 3 ||
          o_busy3 !== 3 || o_busy0 !== 0) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: r0 %0d@%0d r3 %0d@%0d busy %0d/%0d, want 1@0 1@3 busy 0/3",
                 it, o_rdy0_cnt, o_rdy0_at, o_rdy3_cnt, o_rdy3_at, o_busy0, o_busy3);
      end
      n_chk++;
      if (o_err0 !== m_err || o_err3 !== m_err) begin
        n_fail++; $display("FAIL rand_error[%0d]: got %b/%b, want %b", it, o_err0, o_err3, m_err);
      end
      n_chk++;
      if (rd0 !== m_rd || rd3 !== m_rd) begin
        n_fail++; $display("FAIL rand_readdata[%0d]: got %h/%h, want %h", it, rd0, rd3, m_rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rd  = 32'h0;
    m_err = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_word();
    test_byte_signed();
    test_half_wrap();
    test_reject();
    test_misalign();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
